exec_unit_mc: RTL and testbench

EXEC_UNIT_MC -- requirements
Module: exec_unit_mc

---
 rtl/exec_unit_mc.sv | 132 +++++++++++++
 tb/tb_exec_unit_mc.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit_mc.sv
// Multi-cycle execute unit: one instruction at a time, result held on the CDB until cdb_ready.
// Latency is 2/4/6 edges for add-sub-address/mul/div and 1 for illegal funcs; flush and reset kill the op.
module exec_unit_mc #(
  parameter int DATA_W  = 8,
  parameter int TAG_W   = 3,
  parameter int RD_W    = 4,
  parameter int LAT_AS  = 2,
  parameter int LAT_MUL = 4,
  parameter int LAT_DIV = 6
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [3:0]          func,
  input  logic [DATA_W-1:0]   rs1_data,
  input  logic [DATA_W-1:0]   rs2_data,
  input  logic [TAG_W-1:0]    rob_ind,
  input  logic [RD_W-1:0]     rd,
  input  logic                flush,
  output logic                cdb_valid,
  input  logic                cdb_ready,
  output logic [2*DATA_W-1:0] cdb_result,
  output logic [TAG_W-1:0]    cdb_rob,
  output logic [RD_W-1:0]     cdb_rd,
  output logic                cdb_mem,
  output logic                cdb_exc,
  output logic                busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int LAT_MAX = (LAT_AS > LAT_MUL) ? ((LAT_AS > LAT_DIV) ? LAT_AS : LAT_DIV)
                                              : ((LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV);
  localparam int CNT_W = $clog2(LAT_MAX + 1);

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [3:0]          func_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [2*DATA_W-1:0] a_x, b_x, res_n;
  logic                exc_n, mem_n;

  function automatic logic [CNT_W-1:0] lat_of(input logic [3:0] f);
    case (f)
      4'b0000, 4'b0001, 4'b0100, 4'b0101: lat_of = CNT_W'(LAT_AS);
      4'b0010:                            lat_of = CNT_W'(LAT_MUL);
      4'b0011:                            lat_of = CNT_W'(LAT_DIV);
      default:                            lat_of = CNT_W'(1);
    endcase
  endfunction

  assign a_x = {{DATA_W{1'b0}}, a_q};
  assign b_x = {{DATA_W{1'b0}}, b_q};

  always_comb begin
    res_n = '0;
    exc_n = 1'b0;
    mem_n = 1'b0;
    case (func_q)
      4'b0000: res_n = a_x + b_x;
      4'b0001: res_n = a_x - b_x;
      4'b0010: res_n = a_x * b_x;
      4'b0011: begin
        // divide by zero: all-ones quotient, dividend passed through as remainder
        if (b_q == '0) begin
          res_n = {a_q, {DATA_W{1'b1}}};
          exc_n = 1'b1;
        end else begin
          res_n = {a_q % b_q, a_q / b_q};
        end
      end
      4'b0100, 4'b0101: begin
        res_n = a_x + b_x;
        mem_n = 1'b1;
      end
      default: exc_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      func_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cdb_result <= '0;
      cdb_rob    <= '0;
      cdb_rd     <= '0;
      cdb_mem    <= 1'b0;
      cdb_exc    <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_valid) begin
            func_q  <= func;
            a_q     <= rs1_data;
            b_q     <= rs2_data;
            cdb_rob <= rob_ind;
            cdb_rd  <= rd;
            cnt     <= lat_of(func);
            state   <= EXEC;
          end
        end
        EXEC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            cdb_result <= res_n;
            cdb_mem    <= mem_n;
            cdb_exc    <= exc_n;
            state      <= DONE;
          end
        end
        DONE: begin
          if (cdb_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign issue_ready = (state == IDLE);
  assign cdb_valid   = (state == DONE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed bench for exec_unit_mc: arithmetic table, backpressure, flush, reset and back-to-back issue.
module tb_exec_unit_mc;

  logic        clk1, rst_n;
  logic        issue_valid, issue_ready;
  logic [3:0]  func;
  logic [7:0]  rs1_data, rs2_data;
  logic [2:0]  rob_ind;
  logic [3:0]  rd;
  logic        flush;
  logic        cdb_valid, cdb_ready;
  logic [15:0] cdb_result;
  logic [2:0]  cdb_rob;
  logic [3:0]  cdb_rd;
  logic        cdb_mem, cdb_exc, busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]  f;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  rob;
    logic [3:0]  rd;
    int          lat;
    logic [15:0] res;
    logic        exc;
    logic        mem;
  } vec_t;

  exec_unit_mc dut (
    .clk1(clk1), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .func(func), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rob_ind(rob_ind), .rd(rd), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
    .cdb_result(cdb_result), .cdb_rob(cdb_rob), .cdb_rd(cdb_rd),
    .cdb_mem(cdb_mem), .cdb_exc(cdb_exc), .busy(busy)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  // Accepts on the next edge, then scrambles the inputs so late changes would show up in the result.
  task automatic do_issue(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] rob, input logic [3:0] r);
    issue_valid = 1'b1; func = f; rs1_data = a; rs2_data = b; rob_ind = rob; rd = r;
    step();
    issue_valid = 1'b0; func = 4'b0010; rs1_data = 8'hA5; rs2_data = 8'h5A; rob_ind = 3'd0; rd = 4'd0;
  endtask

  task automatic wait_valid(input int lat, output int early);
    early = 0;
    for (int k = 1; k <= lat; k++) begin
      step();
      if (k < lat && cdb_valid) early = 1;
    end
  endtask

  task automatic retire();
    cdb_ready = 1'b1;
    step();
    cdb_ready = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({issue_ready, cdb_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_ctrl: rdy/vld/busy got %b want 100", {issue_ready, cdb_valid, busy});
    end
    vectors++;
    if ({cdb_result, cdb_rob, cdb_rd, cdb_mem, cdb_exc} !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_data: got %h/%h/%h/%b/%b want all 0", cdb_result, cdb_rob, cdb_rd, cdb_mem, cdb_exc);
    end
  endtask

  task automatic test_arith();
    vec_t t[8];
    int   early;
    t[0] = '{4'b0000, 8'hF0, 8'h20, 3'd5, 4'd3,  2, 16'h0110, 1'b0, 1'b0};
    t[1] = '{4'b0010, 8'hFF, 8'hFF, 3'd1, 4'd2,  4, 16'hFE01, 1'b0, 1'b0};
    t[2] = '{4'b0011, 8'd200, 8'd7, 3'd2, 4'd4,  6, 16'h041C, 1'b0, 1'b0};
    t[3] = '{4'b0011, 8'h33, 8'h00, 3'd3, 4'd5,  6, 16'h33FF, 1'b1, 1'b0};
    t[4] = '{4'b1010, 8'h12, 8'h34, 3'd7, 4'd6,  1, 16'h0000, 1'b1, 1'b0};
    t[5] = '{4'b0001, 8'h05, 8'h07, 3'd4, 4'd8,  2, 16'hFFFE, 1'b0, 1'b0};
    t[6] = '{4'b0100, 8'h12, 8'h34, 3'd6, 4'd9,  2, 16'h0046, 1'b0, 1'b1};
    t[7] = '{4'b0101, 8'hFF, 8'hFF, 3'd0, 4'd15, 2, 16'h01FE, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      do_issue(t[i].f, t[i].a, t[i].b, t[i].rob, t[i].rd);
      vectors++;
      if ({busy, issue_ready} !== 2'b10) begin
        miscompares++;
        $display("FAIL arith[%0d] accept: busy/rdy got %b want 10", i, {busy, issue_ready});
      end
      wait_valid(t[i].lat, early);
      vectors++;
      if (early != 0 || cdb_valid !== 1'b1 || issue_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL arith[%0d] latency: early=%0d vld=%b rdy=%b want valid first at edge %0d with rdy 0",
                 i, early, cdb_valid, issue_ready, t[i].lat);
      end
      vectors++;
      if (cdb_result !== t[i].res) begin
        miscompares++;
        $display("FAIL arith[%0d] result: got %h want %h", i, cdb_result, t[i].res);
      end
      vectors++;
      if ({cdb_rob, cdb_rd} !== {t[i].rob, t[i].rd}) begin
        miscompares++;
        $display("FAIL arith[%0d] tags: rob/rd got %0d/%0d want %0d/%0d", i, cdb_rob, cdb_rd, t[i].rob, t[i].rd);
      end
      vectors++;
      if ({cdb_exc, cdb_mem} !== {t[i].exc, t[i].mem}) begin
        miscompares++;
        $display("FAIL arith[%0d] flags: exc/mem got %b%b want %b%b", i, cdb_exc, cdb_mem, t[i].exc, t[i].mem);
      end
      retire();
      vectors++;
      if ({issue_ready, cdb_valid, busy} !== 3'b100) begin
        miscompares++;
        $display("FAIL arith[%0d] retire: rdy/vld/busy got %b want 100", i, {issue_ready, cdb_valid, busy});
      end
    end
  endtask

  task automatic test_backpressure();
    int early;
    do_issue(4'b0010, 8'h0C, 8'h0B, 3'd6, 4'd9);
    wait_valid(4, early);
    issue_valid = 1'b1; func = 4'b0000; rs1_data = 8'h01; rs2_data = 8'h01; rob_ind = 3'd1;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (early != 0 || cdb_valid !== 1'b1 || issue_ready !== 1'b0 || cdb_result !== 16'h0084 ||
          cdb_rob !== 3'd6 || cdb_rd !== 4'd9 || cdb_exc !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure[%0d]: vld=%b rdy=%b res=%h rob=%0d rd=%0d exc=%b want 1 0 0084 6 9 0",
                 c, cdb_valid, issue_ready, cdb_result, cdb_rob, cdb_rd, cdb_exc);
      end
      step();
    end
    issue_valid = 1'b0;
    retire();
    vectors++;
    if ({issue_ready, cdb_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL backpressure_release: rdy/vld/busy got %b want 100", {issue_ready, cdb_valid, busy});
    end
  endtask

  task automatic test_flush();
    bit seen;
    do_issue(4'b0011, 8'd100, 8'd3, 3'd2, 4'd1);
    step();
    step();
    flush = 1'b1;
    issue_valid = 1'b1; func = 4'b0000; rs1_data = 8'h01; rs2_data = 8'h02;
    step();
    flush = 1'b0;
    issue_valid = 1'b0;
    vectors++;
    if ({issue_ready, cdb_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL flush_idle: rdy/vld/busy got %b want 100", {issue_ready, cdb_valid, busy});
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (cdb_valid || busy) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_quiet: activity after flush got %b want 0", seen);
    end
  endtask

  task automatic test_reset_midop();
    int early;
    bit seen;
    do_issue(4'b0000, 8'h11, 8'h22, 3'd4, 4'd7);
    wait_valid(2, early);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({cdb_valid, busy, issue_ready} !== 3'b001 || cdb_result !== 16'h0 || cdb_rob !== 3'd0 ||
        cdb_rd !== 4'd0 || cdb_mem !== 1'b0 || cdb_exc !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done_async: vld/busy/rdy=%b res=%h rob=%0d rd=%0d want 001 0000 0 0",
               {cdb_valid, busy, issue_ready}, cdb_result, cdb_rob, cdb_rd);
    end
    @(negedge clk1) rst_n = 1'b1;
    step();
    do_issue(4'b0011, 8'd50, 8'd5, 3'd3, 4'd2);
    step();
    step();
    #2 rst_n = 1'b0;
    @(negedge clk1) rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (cdb_valid || busy) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_exec_quiet: activity after reset got %b want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int early;
    do_issue(4'b0000, 8'h01, 8'h02, 3'd1, 4'd1);
    wait_valid(2, early);
    cdb_ready = 1'b1;
    issue_valid = 1'b1; func = 4'b0001; rs1_data = 8'h10; rs2_data = 8'h01; rob_ind = 3'd2; rd = 4'd7;
    step();
    cdb_ready = 1'b0;
    vectors++;
    if ({issue_ready, cdb_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL b2b_no_same_cycle: rdy/vld/busy got %b want 100", {issue_ready, cdb_valid, busy});
    end
    step();
    issue_valid = 1'b0; rs1_data = 8'hEE; rs2_data = 8'hEE; rob_ind = 3'd0; rd = 4'd0;
    wait_valid(2, early);
    vectors++;
    if (early != 0 || cdb_valid !== 1'b1 || cdb_result !== 16'h000F || cdb_rob !== 3'd2 || cdb_rd !== 4'd7) begin
      miscompares++;
      $display("FAIL b2b_second: early=%0d vld=%b res=%h rob=%0d rd=%0d want 0 1 000F 2 7",
               early, cdb_valid, cdb_result, cdb_rob, cdb_rd);
    end
    retire();
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; func = 4'b0000; rs1_data = 8'h00; rs2_data = 8'h00;
    rob_ind = 3'd0; rd = 4'd0; flush = 1'b0; cdb_ready = 1'b0;
    repeat (3) @(negedge clk1);
    rst_n = 1'b1;
    step();
    test_reset();
    test_arith();
    test_backpressure();
    test_flush();
    test_reset_midop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
